// File: rtl/maze_pkg.sv
// Shared types for the wall-following maze solver: directions, headings, FSM states, turn codes.
package maze_pkg;

    // Counterclockwise encoding so a left turn is +1 and a right turn is -1 (mod 4).
    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_W = 2'd1,
        DIR_S = 2'd2,
        DIR_E = 2'd3
    } dir_t;

    localparam logic [11:0] HDNG_N = 12'h000;
    localparam logic [11:0] HDNG_W = 12'h3FF;
    localparam logic [11:0] HDNG_S = 12'h7FF;
    localparam logic [11:0] HDNG_E = 12'hC00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_HDNG,
        ST_WAIT_H,
        ST_MOVE,
        ST_WAIT_M,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        TURN_STRAIGHT = 2'd0,
        TURN_LEFT     = 2'd1,
        TURN_RIGHT    = 2'd2,
        TURN_UTURN    = 2'd3
    } turn_t;

    function automatic logic [11:0] dir2hdng(input dir_t d);
        logic [11:0] h;
        h = HDNG_N;
        case (d)
            DIR_N:   h = HDNG_N;
            DIR_W:   h = HDNG_W;
            DIR_S:   h = HDNG_S;
            DIR_E:   h = HDNG_E;
            default: h = HDNG_N;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/turn_sel.sv
// Combinational wall-follower turn choice: followed wall first, then straight, then far wall, else U-turn.
// Zero latency; no flow control.
module turn_sel
    import maze_pkg::*;
#(
    parameter bit LFT_HAND = 1'b1
) (
    input  logic  lft_opn_i,
    input  logic  rght_opn_i,
    input  logic  frwrd_opn_i,
    output turn_t turn_o
);

    always_comb begin
        turn_o = TURN_UTURN;
        if (LFT_HAND) begin
            if (lft_opn_i)        turn_o = TURN_LEFT;
            else if (frwrd_opn_i) turn_o = TURN_STRAIGHT;
            else if (rght_opn_i)  turn_o = TURN_RIGHT;
        end else begin
            if (rght_opn_i)       turn_o = TURN_RIGHT;
            else if (frwrd_opn_i) turn_o = TURN_STRAIGHT;
            else if (lft_opn_i)   turn_o = TURN_LEFT;
        end
    end

endmodule

// File: rtl/maze_solver_sm.sv
// Maze-solving command initiator: settles, samples IR openings, requests heading/move, waits on mv_cmplt.
// Requests are single-cycle registered pulses; each outstanding request blocks until mv_cmplt returns.
module maze_solver_sm
    import maze_pkg::*;
#(
    parameter bit          LFT_HAND   = 1'b1,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_md,
    input  logic        sol_cmplt,
    input  logic        mv_cmplt,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        frwrd_opn,
    output logic        strt_hdng,
    output logic        strt_mv,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic [11:0] dsrd_hdng,
    output logic        solved
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    state_t      state_q, state_d;
    dir_t        dir_q, dir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sol_q, sol_d;
    logic [11:0] dsrd_hdng_q;
    logic        strt_hdng_q, strt_mv_q, solved_q;
    turn_t       turn;

    turn_sel #(.LFT_HAND(LFT_HAND)) u_turn_sel (
        .lft_opn_i   (lft_opn),
        .rght_opn_i  (rght_opn),
        .frwrd_opn_i (frwrd_opn),
        .turn_o      (turn)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        sol_d   = sol_q;
        case (state_q)
            ST_IDLE: begin
                sol_d = 1'b0;
                if (cmd_md) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (sol_cmplt || sol_q) begin
                    state_d = ST_DONE;
                end else if (!cmd_md) begin
                    state_d = ST_IDLE;
                end else begin
                    case (turn)
                        TURN_STRAIGHT: state_d = ST_MOVE;
                        TURN_LEFT: begin
                            dir_d   = dir_t'(dir_q + 2'd1);
                            state_d = ST_HDNG;
                        end
                        TURN_RIGHT: begin
                            dir_d   = dir_t'(dir_q - 2'd1);
                            state_d = ST_HDNG;
                        end
                        default: begin
                            dir_d   = dir_t'(dir_q + 2'd2);
                            state_d = ST_HDNG;
                        end
                    endcase
                end
            end
            ST_HDNG:   state_d = ST_WAIT_H;
            ST_WAIT_H: if (mv_cmplt) state_d = ST_MOVE;
            ST_MOVE:   state_d = ST_WAIT_M;
            ST_WAIT_M: begin
                // Goal seen mid-move must survive until the next decision point.
                if (sol_cmplt) sol_d = 1'b1;
                if (mv_cmplt) begin
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE:   if (!cmd_md) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_N;
            cnt_q       <= 4'd0;
            sol_q       <= 1'b0;
            dsrd_hdng_q <= HDNG_N;
            strt_hdng_q <= 1'b0;
            strt_mv_q   <= 1'b0;
            solved_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            cnt_q       <= cnt_d;
            sol_q       <= sol_d;
            strt_hdng_q <= (state_d == ST_HDNG);
            strt_mv_q   <= (state_d == ST_MOVE);
            solved_q    <= (state_d == ST_DONE);
            if (state_d == ST_HDNG) dsrd_hdng_q <= dir2hdng(dir_d);
        end
    end

    assign strt_hdng = strt_hdng_q;
    assign strt_mv   = strt_mv_q;
    assign solved    = solved_q;
    assign dsrd_hdng = dsrd_hdng_q;
    assign stp_lft   = LFT_HAND;
    assign stp_rght  = ~LFT_HAND;

endmodule

// File: tb/tb_maze_solver_sm.sv
// Directed bench: left-hand solver walked through a hand-computed turn sequence, plus a right-hand instance.
module tb_maze_solver_sm;

    localparam int SC = 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n, cmd_md, cmd_md_r, sol_cmplt, mv_cmplt, mv_r;
    logic lft_opn, rght_opn, frwrd_opn;
    logic strt_hdng, strt_mv, stp_lft, stp_rght, solved;
    logic strt_hdng_r, strt_mv_r, stp_lft_r, stp_rght_r, solved_r;
    logic [11:0] dsrd_hdng, dsrd_hdng_r;

    int checks = 0;
    int failures = 0;

    maze_solver_sm #(.LFT_HAND(1'b1), .SETTLE_CYC(SC)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .sol_cmplt(sol_cmplt),
        .mv_cmplt(mv_cmplt), .lft_opn(lft_opn), .rght_opn(rght_opn),
        .frwrd_opn(frwrd_opn), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
        .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng),
        .solved(solved)
    );

    maze_solver_sm #(.LFT_HAND(1'b0), .SETTLE_CYC(SC)) u_dut_r (
        .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md_r), .sol_cmplt(1'b0),
        .mv_cmplt(mv_r), .lft_opn(lft_opn), .rght_opn(rght_opn),
        .frwrd_opn(frwrd_opn), .strt_hdng(strt_hdng_r), .strt_mv(strt_mv_r),
        .stp_lft(stp_lft_r), .stp_rght(stp_rght_r), .dsrd_hdng(dsrd_hdng_r),
        .solved(solved_r)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_req(input bit sel, input int maxc, output int cyc,
                            output bit saw_h, output bit saw_m);
        cyc = 0; saw_h = 1'b0; saw_m = 1'b0;
        while (cyc < maxc && !saw_h && !saw_m) begin
            @(negedge clk);
            cyc++;
            saw_h = sel ? strt_hdng_r : strt_hdng;
            saw_m = sel ? strt_mv_r   : strt_mv;
        end
    endtask

    // From WAIT_M: set openings, complete the move, expect the next request after settle.
    task automatic do_step(input string tag, input logic [2:0] opn, input bit exp_turn,
                           input logic [11:0] exp_h);
        int cyc; bit h, m;
        {lft_opn, rght_opn, frwrd_opn} = opn;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        wait_req(1'b0, 20, cyc, h, m);
        chk({tag, "_lat"}, cyc, SC + 1);
        chk({tag, "_hreq"}, 32'(h), 32'(exp_turn));
        chk({tag, "_mreq"}, 32'(m), 32'(!exp_turn));
        chk({tag, "_hdng"}, 32'(dsrd_hdng), 32'(exp_h));
        if (exp_turn) begin
            @(negedge clk);
            chk({tag, "_h1w"}, 32'(strt_hdng), 0);
            mv_cmplt = 1'b1;
            @(negedge clk);
            mv_cmplt = 1'b0;
            chk({tag, "_mv_after_h"}, 32'(strt_mv), 1);
        end
        @(negedge clk);
        chk({tag, "_m1w"}, 32'(strt_mv), 0);
    endtask

    // {lft, rght, frwrd}; starting heading N, walked in order.
    localparam int NSTEP = 11;
    logic [2:0]  t_opn  [NSTEP] = '{3'b001, 3'b101, 3'b011, 3'b000, 3'b010, 3'b111,
                                    3'b100, 3'b000, 3'b100, 3'b100, 3'b010};
    bit          t_turn [NSTEP] = '{0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    logic [11:0] t_hdng [NSTEP] = '{12'h000, 12'h3FF, 12'h3FF, 12'hC00, 12'h7FF, 12'hC00,
                                    12'h000, 12'h7FF, 12'hC00, 12'h000, 12'hC00};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, npulse;
        bit h, m;
        rst_n = 1'b0; cmd_md = 1'b0; cmd_md_r = 1'b0; sol_cmplt = 1'b0;
        mv_cmplt = 1'b0; mv_r = 1'b0;
        lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hdng", 32'(strt_hdng), 0);
        chk("rst_mv", 32'(strt_mv), 0);
        chk("rst_solved", 32'(solved), 0);
        chk("rst_dsrd", 32'(dsrd_hdng), 0);
        chk("rst_stp_lft", 32'(stp_lft), 1);
        chk("rst_stp_rght", 32'(stp_rght), 0);
        chk("rst_r_stp_lft", 32'(stp_lft_r), 0);
        chk("rst_r_stp_rght", 32'(stp_rght_r), 1);

        // First move: forward only, straight from IDLE.
        rst_n = 1'b1;
        frwrd_opn = 1'b1;
        cmd_md = 1'b1;
        @(negedge clk);
        wait_req(1'b0, 20, cyc, h, m);
        chk("first_lat", cyc, SC + 1);
        chk("first_mreq", 32'(m), 1);
        chk("first_hreq", 32'(h), 0);
        chk("first_dsrd", 32'(dsrd_hdng), 0);
        @(negedge clk);
        chk("first_m1w", 32'(strt_mv), 0);

        for (int i = 0; i < NSTEP; i++)
            do_step($sformatf("step%0d", i), t_opn[i], t_turn[i], t_hdng[i]);

        // Goal seen mid-move: no further requests, DONE after settle.
        sol_cmplt = 1'b1;
        @(negedge clk);
        sol_cmplt = 1'b0;
        {lft_opn, rght_opn, frwrd_opn} = 3'b001;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (strt_hdng || strt_mv) npulse++;
        end
        chk("sol_no_req", npulse, 0);
        chk("sol_solved", 32'(solved), 1);
        chk("sol_dsrd_keep", 32'(dsrd_hdng), 32'h0C00);
        cmd_md = 1'b0;
        @(negedge clk);
        chk("sol_idle", 32'(solved), 0);
        cmd_md = 1'b1;
        @(negedge clk);
        wait_req(1'b0, 20, cyc, h, m);
        chk("resume_lat", cyc, SC + 1);
        chk("resume_mreq", 32'(m), 1);
        chk("resume_dsrd", 32'(dsrd_hdng), 32'h0C00);
        @(negedge clk);

        // Right turn E->S, then reset while waiting on the heading.
        {lft_opn, rght_opn, frwrd_opn} = 3'b010;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        wait_req(1'b0, 20, cyc, h, m);
        chk("pre_rst_hreq", 32'(h), 1);
        chk("pre_rst_dsrd", 32'(dsrd_hdng), 32'h07FF);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_md = 1'b0;
        #1;
        chk("arst_dsrd", 32'(dsrd_hdng), 0);
        chk("arst_hdng", 32'(strt_hdng), 0);
        chk("arst_mv", 32'(strt_mv), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mv_cmplt = 1'b1;
        @(negedge clk);
        mv_cmplt = 1'b0;
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (strt_hdng || strt_mv) npulse++;
        end
        chk("post_rst_no_req", npulse, 0);
        chk("post_rst_dsrd", 32'(dsrd_hdng), 0);

        // Direction must be back at N: a left turn lands on W.
        {lft_opn, rght_opn, frwrd_opn} = 3'b001;
        cmd_md = 1'b1;
        @(negedge clk);
        wait_req(1'b0, 20, cyc, h, m);
        chk("rerun_mreq", 32'(m), 1);
        @(negedge clk);
        do_step("rerun_left", 3'b100, 1'b1, 12'h3FF);
        cmd_md = 1'b0;

        // Right-hand follower with both side openings picks the right turn.
        {lft_opn, rght_opn, frwrd_opn} = 3'b111;
        cmd_md_r = 1'b1;
        @(negedge clk);
        wait_req(1'b1, 20, cyc, h, m);
        chk("rh_lat", cyc, SC + 1);
        chk("rh_hreq", 32'(h), 1);
        chk("rh_dsrd", 32'(dsrd_hdng_r), 32'h0C00);
        chk("rh_stp_rght", 32'(stp_rght_r), 1);
        chk("rh_stp_lft", 32'(stp_lft_r), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_solver_sm.md
Name: maze_solver_sm

Overview:
- Command initiator that drives the navigation state machine: issues heading-change and forward-move requests and waits on mv_cmplt between them.
- Implements a wall-following maze solution, left-hand or right-hand by parameter, using IR opening flags sampled after each completed move.
- Sits between the command/enable logic and the navigation block. It is the requesting end of the strt_hdng / strt_mv / stp_lft / stp_rght / mv_cmplt protocol.

Parameters:
LFT_HAND, 1, 1 = left-wall follower, 0 = right-wall follower.
SETTLE_CYC, 4, clocks to wait after a completed move (and at start) before sampling IR flags; legal range 1..15.

Ports:
clk  input  1  50MHz system clock
rst_n  input  1  asynchronous active-low reset
cmd_md  input  1  level; high enables autonomous solving
sol_cmplt  input  1  goal (magnet) detected; level
mv_cmplt  input  1  one-cycle pulse from navigation: heading or move finished
lft_opn  input  1  IR: left opening present
rght_opn  input  1  IR: right opening present
frwrd_opn  input  1  IR: forward path open
strt_hdng  output  1  one-cycle pulse requesting a heading change
strt_mv  output  1  one-cycle pulse requesting a forward move
stp_lft  output  1  stop forward move at first left opening
stp_rght  output  1  stop forward move at first right opening
dsrd_hdng  output  12  desired heading to PID
solved  output  1  high while in DONE

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low rst_n.
- Reset values:
  - state = IDLE, direction register = NORTH.
  - dsrd_hdng = 12'h000; strt_hdng, strt_mv, solved = 0.
  - stp_lft = LFT_HAND, stp_rght = ~LFT_HAND. These two are constants: stop at the first opening on the followed wall.
- Direction encoding is 2 bits, counterclockwise: N=0, W=1, S=2, E=3.
  - Left turn = dir+1, right turn = dir-1, U-turn = dir+2, all modulo 4 (wraps: E+1=N, N-1=E).
- Heading map: N=12'h000, W=12'h3FF, S=12'h7FF, E=12'hC00.
  - dsrd_hdng is registered. It updates in the same cycle strt_hdng is asserted and holds until the next heading change.
- All outputs are registered. strt_hdng and strt_mv are exactly one clock wide.
- States:
  - IDLE: waits for cmd_md=1, then loads the settle counter with SETTLE_CYC and goes to SETTLE.
  - SETTLE: counter decrements each clock; at 0 go to DECIDE.
  - DECIDE: one-cycle evaluation. Priority order:
    - sol_cmplt=1 -> DONE.
    - cmd_md=0 -> IDLE.
    - Left-hand order: lft_opn -> turn left; else frwrd_opn -> straight; else rght_opn -> turn right; else U-turn.
    - Right-hand order: swap lft and rght in the above.
    - Any turn -> HDNG (new dir latched). Straight -> MOVE (no heading request).
  - HDNG: pulse strt_hdng with the new dsrd_hdng, then go to WAIT_H.
  - WAIT_H: wait for mv_cmplt, then go to MOVE.
  - MOVE: pulse strt_mv, then go to WAIT_M.
  - WAIT_M: wait for mv_cmplt, then reload the settle counter and go to SETTLE.
  - DONE: solved=1, no requests issued. cmd_md=0 -> IDLE. The direction register is retained.
- Wait states never time out and never abandon an outstanding request.
  - cmd_md falling or sol_cmplt rising while in WAIT_H/WAIT_M is acted on only at the next DECIDE.
  - Exception: sol_cmplt during WAIT_M. sol_cmplt is latched (sticky until IDLE) and forces DONE at DECIDE.
- mv_cmplt outside WAIT_H/WAIT_M is ignored.
- Asynchronous reset mid-operation returns to reset values immediately; no pulse is emitted on the release edge.
- Re-entering IDLE from DONE keeps the current dir and dsrd_hdng. Only reset clears them.

Decomposition:
- Shared package maze_pkg holds:
  - dir_t enum (N,W,S,E).
  - Heading constants HDNG_N/W/S/E.
  - solver state_t enum.
  - Function dir2hdng(dir_t) returning 12 bits.
- Sub-module turn_sel (combinational): inputs lft_opn/rght_opn/frwrd_opn plus LFT_HAND; output 2-bit turn code (STRAIGHT/LEFT/RIGHT/UTURN).
- Remaining logic lives in maze_solver_sm: state register, settle counter, direction register, sticky sol latch.

Test Plan:
- Reset, cmd_md=1, frwrd_opn=1, lft/rght=0 -> after SETTLE_CYC+1 clocks, one strt_mv pulse, no strt_hdng, dsrd_hdng=000; mv_cmplt pulse -> repeats after settle.
- LFT_HAND=1, dir=N, lft_opn=1, frwrd_opn=1 -> strt_hdng with dsrd_hdng=3FF; after mv_cmplt, strt_mv on the next clock.
- All openings 0, dir=N -> U-turn: dsrd_hdng=7FF. Repeat from E with only rght_opn=1 -> dsrd_hdng=7FF (E-1=S); check wrap N->E on a right turn (dsrd_hdng=C00).
- LFT_HAND=0, lft_opn=1, rght_opn=1 -> right turn chosen; stp_rght=1, stp_lft=0 throughout.
- sol_cmplt pulsed mid-WAIT_M -> no further strt_* after mv_cmplt; solved=1 after settle; cmd_md=0 -> IDLE, solved=0.
- rst_n low during WAIT_H -> outputs immediately at reset values; extra mv_cmplt after release produces no pulse.
